snitch_icache_lookup_arbiter: RTL and testbench

Front-end controller for the instruction-cache lookup stage. Round-robin arbitrates several fetch ports onto the single lookup request port and tags each request with its port index in the upper ID bits so downstream logic can route responses. Sequences cache flushes: blocks new lookups, drains in-flight lookups, issues the flush handshake to the lookup stage, then acknowledges every requesting port.

---
 rtl/snitch_icache_lookup_arbiter_if.sv | 45 ++++
 rtl/snitch_icache_lookup_arbiter.sv | 138 +++++++++++++
 tb/tb_snitch_icache_lookup_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_icache_lookup_arbiter_if.sv
// Fetch-port and lookup-stage handshake bundle for the icache lookup arbiter.
// Latency: wires only. No state lives in this interface.
// Backpressure: carries the valid/ready pairs. The slave side is the arbiter.
interface snitch_icache_lookup_arbiter_if #(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned FETCH_AW = 32,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
);

  // Fetch ports
  logic [NR_PORTS-1:0][FETCH_AW-1:0] port_addr_i;
  logic [NR_PORTS-1:0][ID_WIDTH-1:0] port_id_i;
  logic [NR_PORTS-1:0]               port_valid_i;
  logic [NR_PORTS-1:0]               port_ready_o;
  logic [NR_PORTS-1:0]               flush_req_i;
  logic [NR_PORTS-1:0]               flush_ack_o;

  // Lookup-stage request, monitored response and flush handshake
  logic [FETCH_AW-1:0]               lk_addr_o;
  logic [ID_WIDTH+IDX_W-1:0]         lk_id_o;
  logic                              lk_valid_o;
  logic                              lk_ready_i;
  logic                              lk_out_valid_i;
  logic                              lk_out_ready_i;
  logic                              lk_flush_valid_o;
  logic                              lk_flush_ready_i;

  // Arbiter side
  modport slave (
    input  port_addr_i, port_id_i, port_valid_i, flush_req_i,
    input  lk_ready_i, lk_out_valid_i, lk_out_ready_i, lk_flush_ready_i,
    output port_ready_o, flush_ack_o, lk_addr_o, lk_id_o, lk_valid_o,
    output lk_flush_valid_o
  );

  // Fetch-port / lookup-stage side
  modport master (
    output port_addr_i, port_id_i, port_valid_i, flush_req_i,
    output lk_ready_i, lk_out_valid_i, lk_out_ready_i, lk_flush_ready_i,
    input  port_ready_o, flush_ack_o, lk_addr_o, lk_id_o, lk_valid_o,
    input  lk_flush_valid_o
  );

endinterface

// File: rtl/snitch_icache_lookup_arbiter.sv
// Round-robin arbiter of fetch ports onto the icache lookup port, with a flush sequencer.
// Latency: the request path is combinational, so zero cycles. A flush with no traffic acks 3 cycles after the request.
// Backpressure: a stalled grant is locked until accepted. Grants stop at MAX_OUTSTANDING and while a flush drains.
module snitch_icache_lookup_arbiter #(
  parameter int unsigned NR_PORTS        = 2,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  snitch_icache_lookup_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    ACK   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    arb_idx, grant_idx, grant_q;
  logic                arb_found;
  logic [IDX_W:0]      cand;
  logic                locked_q;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [NR_PORTS-1:0] flush_mask_q, flush_mask_d;
  logic                cnt_full, grant_allowed, lk_valid;
  logic                accept, retire;

  // Pick the first valid port at or after the round-robin pointer, wrapping around.
  always_comb begin
    arb_idx   = rr_q;
    arb_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NR_PORTS)) cand = cand - (IDX_W+1)'(NR_PORTS);
      if (!arb_found && bus.port_valid_i[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // A stalled request keeps its grant, so address and ID stay stable until accepted.
  // The lock also lets a stalled request finish while a flush is draining.
  assign grant_idx     = locked_q ? grant_q : arb_idx;
  assign cnt_full      = (outstanding_q >= CNT_W'(MAX_OUTSTANDING));
  assign grant_allowed = ((state_q == IDLE) || locked_q) && !cnt_full;
  assign lk_valid      = bus.port_valid_i[grant_idx] & grant_allowed;
  assign accept        = lk_valid & bus.lk_ready_i;
  assign retire        = bus.lk_out_valid_i & bus.lk_out_ready_i;
  assign rr_d          = (grant_idx == IDX_W'(NR_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  // Drive the lookup request and route ready back to the granted port only.
  always_comb begin
    bus.port_ready_o            = '0;
    bus.port_ready_o[grant_idx] = bus.lk_ready_i & lk_valid;
    bus.lk_valid_o              = lk_valid;
    bus.lk_addr_o               = lk_valid ? bus.port_addr_i[grant_idx] : '0;
    bus.lk_id_o                 = lk_valid ? {grant_idx, bus.port_id_i[grant_idx]} : '0;
  end

  // Track in-flight lookups. An accept and a retire in the same cycle cancel.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, retire})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Flush sequencer. It collects requesters while draining, hands the flush to the
  // lookup stage, then acks everyone it collected in one pulse.
  always_comb begin
    state_d              = state_q;
    flush_mask_d         = flush_mask_q;
    bus.flush_ack_o      = '0;
    bus.lk_flush_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.flush_req_i) begin
          state_d      = DRAIN;
          flush_mask_d = flush_mask_q | bus.flush_req_i;
        end
      end
      DRAIN: begin
        flush_mask_d = flush_mask_q | bus.flush_req_i;
        if ((outstanding_q == '0) && !lk_valid) state_d = FLUSH;
      end
      FLUSH: begin
        bus.lk_flush_valid_o = 1'b1;
        if (bus.lk_flush_ready_i) state_d = ACK;
      end
      ACK: begin
        bus.flush_ack_o = flush_mask_q;
        flush_mask_d    = '0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset clears everything, including a flush in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      grant_q       <= '0;
      locked_q      <= 1'b0;
      outstanding_q <= '0;
      flush_mask_q  <= '0;
    end else begin
      state_q       <= state_d;
      flush_mask_q  <= flush_mask_d;
      outstanding_q <= outstanding_d;
      locked_q      <= lk_valid & ~bus.lk_ready_i;
      if (lk_valid && !bus.lk_ready_i) grant_q <= grant_idx;
      if (accept) rr_q <= rr_d;
    end
  end

  // Counter must never underflow or overflow, and the flush must not race in-flight lookups.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(retire && !accept && (outstanding_q == '0)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(accept && !retire && cnt_full));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.lk_flush_valid_o |-> (outstanding_q == '0));

endmodule

// File: tb/tb_snitch_icache_lookup_arbiter.sv
// Self-checking bench for snitch_icache_lookup_arbiter with 2 ports and 2 outstanding lookups.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit later.
// Stimulus comes from a directed vector table, flush and reset sequences, and random traffic.
module tb_snitch_icache_lookup_arbiter;

  localparam int NR   = 2;
  localparam int AW   = 32;
  localparam int IDW  = 4;
  localparam int MAXO = 2;
  localparam int IXW  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snitch_icache_lookup_arbiter_if #(.NR_PORTS(NR), .FETCH_AW(AW), .ID_WIDTH(IDW)) bus();

  snitch_icache_lookup_arbiter #(
    .NR_PORTS(NR), .FETCH_AW(AW), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic drive(input logic [1:0] vld, input logic rdy, input logic ret,
                       input logic [1:0] freq, input logic frdy);
    bus.port_valid_i     = vld;
    bus.lk_ready_i       = rdy;
    bus.lk_out_valid_i   = ret;
    bus.lk_out_ready_i   = ret;
    bus.flush_req_i      = freq;
    bus.lk_flush_ready_i = frdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] vld;
    logic       rdy;
    logic       ret;
    logic [1:0] freq;
    logic       frdy;
    logic       evld;
    logic [4:0] eid;
    logic [1:0] eprdy;
    logic       efv;
    logic [1:0] eack;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [1:0] vld, logic rdy, logic ret, logic [1:0] freq,
                              logic frdy, logic evld, logic [4:0] eid, logic [1:0] eprdy,
                              logic efv, logic [1:0] eack);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rdy = rdy; v.ret = ret; v.freq = freq; v.frdy = frdy;
    v.evld = evld; v.eid = eid; v.eprdy = eprdy; v.efv = efv; v.eack = eack;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : main
    vec_t            vt[$];
    logic [31:0]     exp_addr;
    logic [1:0]      fv_a[5];
    logic [1:0]      ack_a[5];
    logic [AW-1:0]   r_addr[NR];
    logic [IDW-1:0]  r_id[NR];
    logic [1:0]      r_vld;
    logic            r_rdy, r_ret;
    int              cnt, last, held, eg;

    drive(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    bus.port_addr_i[0] = 32'h1000;
    bus.port_addr_i[1] = 32'h2000;
    bus.port_id_i[0]   = 4'd3;
    bus.port_id_i[1]   = 4'd5;

    // Reset values
    @(negedge clk); #1;
    check("rst.port_ready", bus.port_ready_o, 0);
    check("rst.flush_ack", bus.flush_ack_o, 0);
    check("rst.lk_valid", bus.lk_valid_o, 0);
    check("rst.lk_flush_valid", bus.lk_flush_valid_o, 0);
    check("rst.lk_addr", bus.lk_addr_o, 0);
    check("rst.lk_id", bus.lk_id_o, 0);

    // Directed cycle table. Port 0: addr 0x1000 id 3 -> {0,3}. Port 1: addr 0x2000 id 5 -> {1,5}.
    //                  rst vld   rdy ret freq  frdy evld eid    eprdy efv eack
    vt.push_back(mk(1, 2'b01, 1, 0, 2'b00, 0, 1, 5'h03, 2'b01, 0, 2'b00)); // single port
    vt.push_back(mk(1, 2'b11, 1, 0, 2'b00, 0, 1, 5'h03, 2'b01, 0, 2'b00)); // alternate from 0
    vt.push_back(mk(0, 2'b11, 1, 1, 2'b00, 0, 1, 5'h15, 2'b10, 0, 2'b00));
    vt.push_back(mk(0, 2'b11, 1, 1, 2'b00, 0, 1, 5'h03, 2'b01, 0, 2'b00));
    vt.push_back(mk(0, 2'b11, 1, 1, 2'b00, 0, 1, 5'h15, 2'b10, 0, 2'b00));
    vt.push_back(mk(0, 2'b10, 0, 1, 2'b00, 0, 1, 5'h15, 2'b00, 0, 2'b00)); // port 1 stalls
    vt.push_back(mk(0, 2'b11, 0, 0, 2'b00, 0, 1, 5'h15, 2'b00, 0, 2'b00)); // port 0 waits
    vt.push_back(mk(0, 2'b11, 0, 0, 2'b00, 0, 1, 5'h15, 2'b00, 0, 2'b00));
    vt.push_back(mk(0, 2'b11, 1, 0, 2'b00, 0, 1, 5'h15, 2'b10, 0, 2'b00)); // accepted
    vt.push_back(mk(0, 2'b11, 1, 0, 2'b00, 0, 1, 5'h03, 2'b01, 0, 2'b00)); // 2 outstanding
    vt.push_back(mk(0, 2'b11, 1, 0, 2'b00, 0, 0, 5'h00, 2'b00, 0, 2'b00)); // full
    vt.push_back(mk(0, 2'b11, 1, 1, 2'b00, 0, 0, 5'h00, 2'b00, 0, 2'b00)); // retire
    vt.push_back(mk(0, 2'b11, 1, 0, 2'b00, 0, 1, 5'h15, 2'b10, 0, 2'b00)); // count 1 -> grant
    vt.push_back(mk(0, 2'b00, 0, 0, 2'b01, 0, 0, 5'h00, 2'b00, 0, 2'b00)); // flush req, 2 in flight
    vt.push_back(mk(0, 2'b00, 0, 1, 2'b01, 0, 0, 5'h00, 2'b00, 0, 2'b00)); // drain
    vt.push_back(mk(0, 2'b00, 0, 1, 2'b11, 0, 0, 5'h00, 2'b00, 0, 2'b00)); // port 1 joins
    vt.push_back(mk(0, 2'b01, 1, 0, 2'b11, 0, 0, 5'h00, 2'b00, 0, 2'b00)); // no grant while draining
    vt.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 5'h00, 2'b00, 1, 2'b00)); // flush valid
    vt.push_back(mk(0, 2'b00, 0, 0, 2'b11, 1, 0, 5'h00, 2'b00, 1, 2'b00)); // flush ready
    vt.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 5'h00, 2'b00, 0, 2'b11)); // ack both
    vt.push_back(mk(0, 2'b01, 1, 0, 2'b00, 0, 1, 5'h03, 2'b01, 0, 2'b00)); // back to service

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      else @(negedge clk);
      drive(vt[i].vld, vt[i].rdy, vt[i].ret, vt[i].freq, vt[i].frdy);
      #1;
      check($sformatf("vec%0d.lk_valid", i), bus.lk_valid_o, vt[i].evld);
      if (vt[i].evld) begin
        exp_addr = vt[i].eid[4] ? 32'h2000 : 32'h1000;
        check($sformatf("vec%0d.lk_id", i), bus.lk_id_o, vt[i].eid);
        check($sformatf("vec%0d.lk_addr", i), bus.lk_addr_o, exp_addr);
      end
      check($sformatf("vec%0d.port_ready", i), bus.port_ready_o, vt[i].eprdy);
      check($sformatf("vec%0d.flush_valid", i), bus.lk_flush_valid_o, vt[i].efv);
      check($sformatf("vec%0d.flush_ack", i), bus.flush_ack_o, vt[i].eack);
    end

    // Flush with no traffic: request at c0, flush valid at c2, ack pulse 2'b01 at c3 only.
    fv_a  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    ack_a = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      drive(2'b00, 1'b0, 1'b0, (c < 4) ? 2'b01 : 2'b00, 1'b1);
      #1;
      check($sformatf("idleflush.c%0d.flush_valid", c), bus.lk_flush_valid_o, fv_a[c]);
      check($sformatf("idleflush.c%0d.flush_ack", c), bus.flush_ack_o, ack_a[c]);
    end

    // Reset asserted during FLUSH: outputs clear, no ack, held request restarts the sequence.
    do_reset();
    drive(2'b00, 1'b0, 1'b0, 2'b10, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rstflush.in_flush", bus.lk_flush_valid_o, 1);
    #2;
    rst_n = 1'b0;
    bus.lk_flush_ready_i = 1'b1;
    #1;
    check("rstflush.flush_valid_cleared", bus.lk_flush_valid_o, 0);
    check("rstflush.ack_none", bus.flush_ack_o, 0);
    check("rstflush.lk_valid", bus.lk_valid_o, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check($sformatf("rstflush.hold%0d.ack", c), bus.flush_ack_o, 0);
    end
    fv_a  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    ack_a = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      drive(2'b00, 1'b0, 1'b0, (c < 4) ? 2'b10 : 2'b00, 1'b1);
      #1;
      check($sformatf("rstflush.c%0d.flush_valid", c), bus.lk_flush_valid_o, fv_a[c]);
      check($sformatf("rstflush.c%0d.flush_ack", c), bus.flush_ack_o, ack_a[c]);
    end

    // Random traffic against a transaction-level model: a count of in-flight lookups,
    // the last port served, and the port whose request is waiting to be accepted.
    do_reset();
    cnt  = 0;
    last = NR - 1;
    held = -1;
    for (int p = 0; p < NR; p++) begin
      r_addr[p] = $urandom;
      r_id[p]   = IDW'($urandom);
    end
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      r_vld = 2'($urandom);
      for (int p = 0; p < NR; p++) begin
        if (p != held) begin
          r_addr[p] = $urandom;
          r_id[p]   = IDW'($urandom);
        end
      end
      if (held >= 0) r_vld[held] = 1'b1;
      r_rdy = ($urandom_range(0, 2) != 0);
      r_ret = (cnt > 0) && ($urandom_range(0, 1) == 1);
      for (int p = 0; p < NR; p++) begin
        bus.port_addr_i[p] = r_addr[p];
        bus.port_id_i[p]   = r_id[p];
      end
      drive(r_vld, r_rdy, r_ret, 2'b00, 1'b0);

      eg = -1;
      if (cnt < MAXO) begin
        if (held >= 0) eg = held;
        else begin
          for (int k = 0; k < NR; k++) begin
            if (eg < 0 && r_vld[(last + 1 + k) % NR]) eg = (last + 1 + k) % NR;
          end
        end
      end

      #1;
      check($sformatf("rand%0d.lk_valid", n), bus.lk_valid_o, (eg >= 0));
      if (eg >= 0) begin
        check($sformatf("rand%0d.lk_id", n), bus.lk_id_o, {IXW'(eg), r_id[eg]});
        check($sformatf("rand%0d.lk_addr", n), bus.lk_addr_o, r_addr[eg]);
        check($sformatf("rand%0d.port_ready", n), bus.port_ready_o,
              r_rdy ? (2'b01 << eg) : 2'b00);
      end else begin
        check($sformatf("rand%0d.port_ready", n), bus.port_ready_o, 2'b00);
      end

      if (eg >= 0 && r_rdy) begin
        cnt++;
        last = eg;
        held = -1;
      end else if (eg >= 0) begin
        held = eg;
      end else begin
        held = -1;
      end
      if (r_ret) cnt--;
    end

    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
